pss_search_ctrl: RTL and testbench
==================================

// Module: pss_search_ctrl
// PURPOSE
//  Sequences the PSS detector between initial search and periodic tracking; sits between PSS_detector and frame_sync.
//  Latches N_id_2 on first peak and confirms it one SSB period later before declaring lock.
//  Once locked, gates detection to a window around the expected peak; drops lock after MAX_MISSES consecutive misses.
// PARAMETERS
//  SSB_PERIOD   19200  SSB repetition period in decimated input samples (counted on s_axis_in_tvalid)
//  WINDOW_HALF  8      half-width of tracking window, samples; must be < SSB_PERIOD/2
//  MAX_MISSES   3      consecutive missed windows in TRACK before sync is declared lost (>=1)
//  CNT_W        $clog2(SSB_PERIOD+WINDOW_HALF+2) (localparam) sample-counter width
// PORTS
//  clk_i                 in   1      clock
//  reset_ni              in   1      asynchronous active-low reset
//  enable_i              in   1      run; low forces IDLE synchronously
//  s_axis_in_tvalid      in   1      decimated sample strobe (same strobe that feeds the detector)
//  N_id_2_valid_i        in   1      detector peak pulse, 1 cycle
//  N_id_2_i              in   2      N_id_2 of the peak, valid with N_id_2_valid_i
//  PSS_detector_mode_o   out  1      0 = search all three N_id_2, 1 = track requested_N_id_2_o only
//  requested_N_id_2_o    out  2      latched N_id_2
//  window_open_o         out  1      detector output accepted this cycle (CONFIRM/TRACK only)
//  lock_o                out  1      high in TRACK
//  sync_lost_o           out  1      1-cycle pulse on TRACK -> SEARCH
//  miss_count_o          out  $clog2(MAX_MISSES+1)  consecutive misses in TRACK
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cnt 0. All outputs registered; updates visible the cycle after the causing input.
//  States: IDLE, SEARCH, CONFIRM, TRACK. IDLE -> SEARCH when enable_i=1. enable_i=0 from any state -> IDLE, outputs to reset values.
//  cnt: on N_id_2 acceptance cnt <= 0; otherwise +1 on each s_axis_in_tvalid. Acceptance wins over increment in the same cycle.
//  Window: window_open = (cnt >= SSB_PERIOD-WINDOW_HALF) && (cnt <= SSB_PERIOD+WINDOW_HALF), in CONFIRM/TRACK only.
//  SEARCH: mode 0. Any N_id_2_valid_i -> latch N_id_2_i into requested, cnt <= 0, go to CONFIRM.
//  CONFIRM: mode 1. Peak inside window with N_id_2_i == requested -> TRACK, cnt <= 0.
//    A peak outside the window, or a peak with a mismatched id, is ignored.
//    Window closes (tvalid while cnt == SSB_PERIOD+WINDOW_HALF, no peak) -> SEARCH, requested cleared. No sync_lost_o pulse.
//  TRACK: mode 1, lock 1. Matching peak inside window -> cnt <= 0, miss_count <= 0. Peaks outside the window are ignored.
//    Window close without peak: miss_count+1 and cnt <= WINDOW_HALF+1, which re-bases to the nominal peak position.
//    If miss_count+1 == MAX_MISSES: go to SEARCH, pulse sync_lost_o, clear miss_count and requested.
//  Simultaneous events: a peak on the window-close cycle counts as a hit. enable_i low overrides everything.
//  Counter saturates at all-ones in SEARCH (it is not needed there).
//  Reset mid-operation: asynchronous return to reset values; no pulse emitted.
// CONFIGURATION
//  Macro PSS_TIMING_ERR_EN.
//  Defined: adds outputs timing_err_o (signed CNT_W+1) and timing_err_valid_o.
//    On each accepted TRACK peak: timing_err_o <= cnt - SSB_PERIOD, valid pulses 1 cycle; reset 0.
//  Undefined: these ports and their logic are absent; all other behaviour is identical.
// TESTING (SSB_PERIOD=100, WINDOW_HALF=4, MAX_MISSES=3, tvalid every cycle)
//  Reset, enable=1, no peaks -> stays SEARCH, mode 0, lock 0, window 0 for 1000 cycles.
//  Acquire and lock:
//    peak id=2 at t0 -> requested=2, mode=1 at t0+1.
//    Peak id=2 at t0+100 -> lock_o=1 at t0+101.
//    window_open_o high for cnt 96..104.
//  Confirm fail:
//    peak id=1, then peak id=0 at +100 (mismatch) and none else -> back to SEARCH one cycle after cnt=104.
//    lock never set.
//  Track misses:
//    locked, peaks stop -> miss_count 1,2 at successive window closes.
//    Third close -> sync_lost_o single pulse, mode 0, requested 0.
//  Hit after miss:
//    locked, one window missed, next peak at nominal+2 -> accepted, miss_count=0.
//    With PSS_TIMING_ERR_EN: timing_err_o=+2.
//  Misc:
//    enable_i dropped in TRACK -> IDLE next cycle, all outputs 0.
//    Peak at cnt=50 in TRACK -> ignored, cnt continues.

Source files
------------

// File: rtl/pss_search_ctrl.sv
// -----------------------------------------------------------------------------
// pss_search_ctrl
//
// Moves the PSS detector between initial search and periodic tracking. It sits
// between the PSS detector and frame sync. The first detector peak latches
// N_id_2. One SSB period later the same N_id_2 must be seen again inside a
// window before lock is declared. Once locked, only peaks that fall inside a
// window around the expected position are accepted. Lock is dropped after
// MAX_MISSES consecutive windows close without a matching peak.
//
// Ports
//   clk_i                in   clock
//   reset_ni             in   asynchronous active-low reset
//   enable_i             in   run enable; low forces IDLE synchronously
//   s_axis_in_tvalid     in   decimated sample strobe; advances the sample counter
//   N_id_2_valid_i       in   detector peak pulse (1 cycle)
//   N_id_2_i             in   N_id_2 of the peak, valid with N_id_2_valid_i
//   PSS_detector_mode_o  out  0 = search all N_id_2, 1 = track requested only
//   requested_N_id_2_o   out  latched N_id_2
//   window_open_o        out  a peak presented this cycle is inside the window
//   lock_o               out  high while tracking
//   sync_lost_o          out  1-cycle pulse when tracking gives up
//   miss_count_o         out  consecutive missed windows while tracking
//   timing_err_o         out  (PSS_TIMING_ERR_EN only) cnt - SSB_PERIOD of last hit
//   timing_err_valid_o   out  (PSS_TIMING_ERR_EN only) 1-cycle pulse per hit
//
// Configuration macro: PSS_TIMING_ERR_EN adds the timing error outputs.
// All outputs are registered.
// -----------------------------------------------------------------------------
module pss_search_ctrl #(
    parameter int SSB_PERIOD  = 19200,
    parameter int WINDOW_HALF = 8,
    parameter int MAX_MISSES  = 3
) (
    input  logic                                        clk_i,
    input  logic                                        reset_ni,
    input  logic                                        enable_i,
    input  logic                                        s_axis_in_tvalid,
    input  logic                                        N_id_2_valid_i,
    input  logic [1:0]                                  N_id_2_i,
    output logic                                        PSS_detector_mode_o,
    output logic [1:0]                                  requested_N_id_2_o,
    output logic                                        window_open_o,
    output logic                                        lock_o,
    output logic                                        sync_lost_o,
    output logic [$clog2(MAX_MISSES+1)-1:0]             miss_count_o
`ifdef PSS_TIMING_ERR_EN
    ,
    output logic signed [$clog2(SSB_PERIOD+WINDOW_HALF+2):0] timing_err_o,
    output logic                                        timing_err_valid_o
`endif
);

    localparam int CNT_W  = $clog2(SSB_PERIOD + WINDOW_HALF + 2);
    localparam int MISS_W = $clog2(MAX_MISSES + 1);

    localparam logic [CNT_W-1:0]  WIN_LO   = CNT_W'(SSB_PERIOD - WINDOW_HALF);
    localparam logic [CNT_W-1:0]  WIN_HI   = CNT_W'(SSB_PERIOD + WINDOW_HALF);
    // One sample past the close position, expressed relative to the nominal peak.
    localparam logic [CNT_W-1:0]  REBASE   = CNT_W'(WINDOW_HALF + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [MISS_W-1:0] MISS_ZERO = {MISS_W{1'b0}};
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MAX_MISSES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_TRACK   = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [1:0]          req_r, req_s;
    logic [MISS_W-1:0]   miss_r, miss_s;
    logic                mode_r, mode_s;
    logic                win_r, win_s;
    logic                lock_r, lock_s;
    logic                lost_r, lost_s;

    logic [CNT_W-1:0]    cnt_inc_s;
    logic [MISS_W-1:0]   miss_inc_s;
    logic                in_win_s;
    logic                win_close_s;
    logic                hit_s;
    logic                track_hit_s;

    // Helper: is a counter value inside the acceptance window.
    function automatic logic in_window(input logic [CNT_W-1:0] c);
        in_window = (c >= WIN_LO) && (c <= WIN_HI);
    endfunction

    // Window qualification terms shared by CONFIRM and TRACK.
    always_comb begin
        cnt_inc_s   = cnt_r + CNT_ONE;
        miss_inc_s  = miss_r + MISS_ONE;
        in_win_s    = in_window(cnt_r);
        // Close is the last in-window sample being consumed.
        win_close_s = s_axis_in_tvalid && (cnt_r == WIN_HI);
        hit_s       = N_id_2_valid_i && in_win_s && (N_id_2_i == req_r);
    end

    // Next-state, counter and bookkeeping decisions.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        req_s       = req_r;
        miss_s      = miss_r;
        lost_s      = 1'b0;
        track_hit_s = 1'b0;
        if (!enable_i) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            req_s   = 2'd0;
            miss_s  = MISS_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_SEARCH;
                    cnt_s   = CNT_ZERO;
                end
                ST_SEARCH: begin
                    if (N_id_2_valid_i) begin
                        state_s = ST_CONFIRM;
                        req_s   = N_id_2_i;
                        cnt_s   = CNT_ZERO;
                    end else if (s_axis_in_tvalid && (cnt_r != CNT_SAT)) begin
                        cnt_s = cnt_inc_s;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_CONFIRM: begin
                    if (hit_s) begin
                        state_s = ST_TRACK;
                        cnt_s   = CNT_ZERO;
                    end else if (win_close_s) begin
                        state_s = ST_SEARCH;
                        req_s   = 2'd0;
                        cnt_s   = cnt_inc_s;
                    end else if (s_axis_in_tvalid) begin
                        cnt_s = cnt_inc_s;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_TRACK: begin
                    if (hit_s) begin
                        cnt_s       = CNT_ZERO;
                        miss_s      = MISS_ZERO;
                        track_hit_s = 1'b1;
                    end else if (win_close_s) begin
                        if (miss_inc_s == MISS_MAX) begin
                            state_s = ST_SEARCH;
                            lost_s  = 1'b1;
                            miss_s  = MISS_ZERO;
                            req_s   = 2'd0;
                            cnt_s   = cnt_inc_s;
                        end else begin
                            miss_s = miss_inc_s;
                            cnt_s  = REBASE;
                        end
                    end else if (s_axis_in_tvalid) begin
                        cnt_s = cnt_inc_s;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    req_s   = 2'd0;
                    miss_s  = MISS_ZERO;
                end
            endcase
        end
    end

    // Output values derived from the next state so they appear registered.
    always_comb begin
        mode_s = (state_s == ST_CONFIRM) || (state_s == ST_TRACK);
        lock_s = (state_s == ST_TRACK);
        if (mode_s) begin
            win_s = in_window(cnt_s);
        end else begin
            win_s = 1'b0;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            req_r   <= 2'd0;
            miss_r  <= MISS_ZERO;
            mode_r  <= 1'b0;
            win_r   <= 1'b0;
            lock_r  <= 1'b0;
            lost_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            req_r   <= req_s;
            miss_r  <= miss_s;
            mode_r  <= mode_s;
            win_r   <= win_s;
            lock_r  <= lock_s;
            lost_r  <= lost_s;
        end
    end

    assign PSS_detector_mode_o = mode_r;
    assign requested_N_id_2_o  = req_r;
    assign window_open_o       = win_r;
    assign lock_o              = lock_r;
    assign sync_lost_o         = lost_r;
    assign miss_count_o        = miss_r;

`ifdef PSS_TIMING_ERR_EN
    localparam logic signed [CNT_W:0] SSB_S = (CNT_W+1)'(SSB_PERIOD);

    logic signed [CNT_W:0] terr_r;
    logic                  terr_vld_r;
    logic signed [CNT_W:0] terr_s;

    // Signed offset of the accepted peak from the nominal position.
    always_comb begin
        terr_s = $signed({1'b0, cnt_r}) - SSB_S;
    end

    // Timing error capture on each accepted tracking peak.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            terr_r     <= '0;
            terr_vld_r <= 1'b0;
        end else if (!enable_i) begin
            terr_r     <= '0;
            terr_vld_r <= 1'b0;
        end else if (track_hit_s) begin
            terr_r     <= terr_s;
            terr_vld_r <= 1'b1;
        end else begin
            terr_vld_r <= 1'b0;
        end
    end

    assign timing_err_o       = terr_r;
    assign timing_err_valid_o = terr_vld_r;
`endif

endmodule

// File: tb/tb_pss_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pss_search_ctrl
//
// Scoreboard bench. A reference model steps on every rising edge from the
// inputs it sees there and pushes the outputs it expects afterwards into a
// queue. A separate monitor pops one entry per cycle and compares it with the
// DUT outputs, sampled just after the edge. Directed sequences cover the
// acquisition, confirm-fail, miss/loss, late-hit and enable-drop cases. A long
// randomized run with a jittered periodic peak source follows.
// -----------------------------------------------------------------------------
module tb_pss_search_ctrl;

    localparam int P  = 100;
    localparam int WH = 4;
    localparam int MM = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       tv = 1'b0;
    logic       pv = 1'b0;
    logic [1:0] id = 2'd0;

    logic       mode_o;
    logic [1:0] req_o;
    logic       win_o;
    logic       lock_o;
    logic       lost_o;
    logic [1:0] miss_o;
`ifdef PSS_TIMING_ERR_EN
    logic signed [7:0] terr_o;
    logic              terr_v_o;
`endif

    pss_search_ctrl #(.SSB_PERIOD(P), .WINDOW_HALF(WH), .MAX_MISSES(MM)) dut (
        .clk_i               (clk),
        .reset_ni            (rst_n),
        .enable_i            (en),
        .s_axis_in_tvalid    (tv),
        .N_id_2_valid_i      (pv),
        .N_id_2_i            (id),
        .PSS_detector_mode_o (mode_o),
        .requested_N_id_2_o  (req_o),
        .window_open_o       (win_o),
        .lock_o              (lock_o),
        .sync_lost_o         (lost_o),
        .miss_count_o        (miss_o)
`ifdef PSS_TIMING_ERR_EN
        ,
        .timing_err_o        (terr_o),
        .timing_err_valid_o  (terr_v_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int req;
        int win;
        int lock;
        int lost;
        int miss;
        int terr;
        int terr_v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    // Described as flags: running (enabled and past the idle cycle), confirming
    // and locked; "since" counts samples since the last accepted peak.
    bit m_running, m_confirming, m_locked;
    int m_since, m_req, m_misses, m_terr;

    task automatic model_clear();
        m_running = 0; m_confirming = 0; m_locked = 0;
        m_since = 0; m_req = 0; m_misses = 0; m_terr = 0;
    endtask

    initial begin
        exp_t e;
        bit in_win, hit, close_now, lost, tv_hit;
        model_clear();
        forever begin
            @(posedge clk);
            lost = 0;
            tv_hit = 0;
            if (!rst_n || !en) begin
                model_clear();
            end else if (!m_running) begin
                m_running = 1;
                m_since = 0;
            end else if (!m_confirming && !m_locked) begin
                if (pv) begin
                    m_req = id;
                    m_since = 0;
                    m_confirming = 1;
                end else if (tv) begin
                    m_since++;
                end
            end else begin
                in_win    = (m_since >= P - WH) && (m_since <= P + WH);
                hit       = pv && in_win && (id == m_req);
                close_now = tv && (m_since == P + WH);
                if (hit) begin
                    if (m_locked) begin
                        m_terr = m_since - P;
                        tv_hit = 1;
                    end
                    m_confirming = 0;
                    m_locked = 1;
                    m_misses = 0;
                    m_since = 0;
                end else if (close_now && m_confirming) begin
                    m_confirming = 0;
                    m_req = 0;
                    m_since++;
                end else if (close_now) begin
                    m_misses++;
                    if (m_misses == MM) begin
                        m_locked = 0;
                        lost = 1;
                        m_misses = 0;
                        m_req = 0;
                        m_since++;
                    end else begin
                        // Position now measured as samples past the nominal peak.
                        m_since = (P + WH + 1) - P;
                    end
                end else if (tv) begin
                    m_since++;
                end
            end
            e.mode   = (m_confirming || m_locked) ? 1 : 0;
            e.req    = m_req;
            e.lock   = m_locked ? 1 : 0;
            e.win    = (e.mode == 1 && m_since >= P - WH && m_since <= P + WH) ? 1 : 0;
            e.lost   = lost ? 1 : 0;
            e.miss   = m_misses;
            e.terr   = m_terr;
            e.terr_v = tv_hit ? 1 : 0;
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mode",      int'(mode_o), e.mode);
                chk("requested", int'(req_o),  e.req);
                chk("window",    int'(win_o),  e.win);
                chk("lock",      int'(lock_o), e.lock);
                chk("sync_lost", int'(lost_o), e.lost);
                chk("miss_count",int'(miss_o), e.miss);
`ifdef PSS_TIMING_ERR_EN
                chk("timing_err_valid", int'(terr_v_o), e.terr_v);
                chk("timing_err", int'(terr_o), e.terr);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic e_i, input logic tv_i, input logic pv_i, input logic [1:0] id_i);
        en = e_i; tv = tv_i; pv = pv_i; id = id_i;
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, 1'b0, 2'd0);
    endtask

    task automatic peak(input logic [1:0] pid);
        cyc(1'b1, 1'b1, 1'b1, pid);
    endtask

    // Watchdog: the run is bounded; an overrun is reported as a failure.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int since;
        int target;
        logic [1:0] src_id;
        @(negedge clk);
        // Reset and disabled: everything at reset values.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 2'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 2'd1);

        // Searching with no peaks.
        quiet(1000);

        // Acquire on id 2, confirm, ignore a mid-period peak, keep tracking.
        peak(2'd2);
        quiet(99);
        peak(2'd2);
        quiet(50);
        peak(2'd2);
        quiet(48);
        peak(2'd2);
        // Mismatched id inside the window is not a hit.
        quiet(99);
        peak(2'd1);
        // Peaks stop: misses accumulate until sync is lost.
        quiet(400);

        // Confirm failure: second peak has the wrong id.
        peak(2'd1);
        quiet(99);
        peak(2'd0);
        quiet(120);

        // Lock on id 3, miss one window, hit late at nominal+2, then a hit
        // exactly on the window-close sample.
        peak(2'd3);
        quiet(99);
        peak(2'd3);
        quiet(105);
        quiet(97);
        peak(2'd3);
        quiet(104);
        peak(2'd3);
        quiet(20);

        // Enable dropped while tracking.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 2'd0);

        // Randomized run with a jittered periodic source and spurious peaks.
        since  = 0;
        target = 99;
        src_id = 2'($urandom_range(0, 2));
        for (int k = 0; k < 20000; k++) begin
            logic e_b, tv_b, pv_b;
            logic [1:0] id_b;
            if (k == 9000) begin
                rst_n = 1'b0;
                cyc(1'b1, 1'b1, 1'b0, 2'd0);
                cyc(1'b1, 1'b1, 1'b1, 2'd0);
                rst_n = 1'b1;
            end
            if (k % 3000 == 0) src_id = 2'($urandom_range(0, 3));
            e_b  = ($urandom_range(0, 999) != 0);
            tv_b = ($urandom_range(0, 9) != 0);
            pv_b = 1'b0;
            id_b = 2'($urandom_range(0, 3));
            if (since >= target) begin
                pv_b   = ($urandom_range(0, 4) != 0);
                id_b   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : src_id;
                since  = 0;
                target = 96 + $urandom_range(0, 8);
            end else if ($urandom_range(0, 199) == 0) begin
                pv_b = 1'b1;
            end
            if (tv_b) since++;
            cyc(e_b, tv_b, pv_b, id_b);
        end

        quiet(3);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
